cpu_boot_ctrl: RTL and testbench

Host-side sequencer for the pipelined `cpu`. It owns that core's external memory ports and its `enable` input. On `start` it streams a program into instruction memory and an initial image into data memory, then runs the core for a programmed number of cycles. It then streams a window of data memory back out and reports `done`.

---
 rtl/cpu_boot_pkg.sv | 51 +++++
 rtl/boot_word_ctr.sv | 28 ++
 rtl/cpu_boot_ctrl.sv | 254 +++++++++++++++++++++++++
 tb/tb_cpu_boot_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_boot_pkg.sv
// Shared definitions for the CPU boot sequencer: the state encoding,
// the order in which session phases run, and the default address shift.
package cpu_boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LD_IMEM = 3'd1,
        ST_LD_DMEM = 3'd2,
        ST_RUN     = 3'd3,
        ST_DUMP_RD = 3'd4,
        ST_DUMP_WT = 3'd5,
        ST_DONE    = 3'd6
    } boot_state_t;

    // Word index to byte address: memories are word-addressed, the core's
    // external ports take byte addresses.
    localparam int DEFAULT_ADDR_SHIFT = 2;

    // Phase order within a session; a phase with a zero length is skipped.
    localparam int PH_IMEM    = 0;
    localparam int PH_DMEM    = 1;
    localparam int PH_RUN     = 2;
    localparam int PH_DUMP    = 3;
    localparam int NUM_PHASES = 4;

    function automatic boot_state_t phase_state(input int ph);
        boot_state_t s;
        case (ph)
            PH_IMEM: s = ST_LD_IMEM;
            PH_DMEM: s = ST_LD_DMEM;
            PH_RUN:  s = ST_RUN;
            PH_DUMP: s = ST_DUMP_RD;
            default: s = ST_DONE;
        endcase
        return s;
    endfunction

    // First phase at or after from_ph whose length is nonzero, else DONE.
    function automatic boot_state_t next_phase(input int from_ph,
                                               input logic [NUM_PHASES-1:0] nz);
        boot_state_t r;
        r = ST_DONE;
        for (int i = NUM_PHASES - 1; i >= 0; i--) begin
            if (i >= from_ph && nz[i]) begin
                r = phase_state(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/boot_word_ctr.sv
// Clearable up-counter with a terminal-count flag. The sequencer uses one
// instance for word indices and one for RUN cycles.
module boot_word_ctr #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    // Clear wins over increment so a phase change restarts at index 0.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign last = (cnt == limit - CNT_W'(1));

endmodule

// File: rtl/cpu_boot_ctrl.sv
// Host-side sequencer for the pipelined cpu: loads instruction and data
// memory from a valid/ready stream, runs the core for a set number of
// cycles, then streams a window of data memory back out.
module cpu_boot_ctrl
    import cpu_boot_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int IMEM_WORDS = 512,
    parameter int DMEM_WORDS = 1024,
    parameter int CNT_W      = 32,
    parameter int ADDR_SHIFT = DEFAULT_ADDR_SHIFT
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  imem_len,
    input  logic [CNT_W-1:0]  dmem_len,
    input  logic [CNT_W-1:0]  dump_len,
    input  logic [CNT_W-1:0]  run_cycles,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic              enable,
    output logic [31:0]       addr_ext,
    output logic [31:0]       wdata_ext,
    output logic              wen_ext,
    output logic              ren_ext,
    input  logic [31:0]       rdata_ext,
    output logic [31:0]       addr_ext_2,
    output logic [31:0]       wdata_ext_2,
    output logic              wen_ext_2,
    output logic              ren_ext_2,
    input  logic [31:0]       rdata_ext_2
);

    function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] len,
                                                   input int max_words);
        if (len > CNT_W'(max_words)) begin
            return CNT_W'(max_words);
        end
        return len;
    endfunction

    function automatic logic [31:0] word_addr(input logic [CNT_W-1:0] idx);
        logic [31:0] a;
        a = 32'(idx);
        return a << ADDR_SHIFT;
    endfunction

    boot_state_t state;

    logic [CNT_W-1:0] imem_len_q;
    logic [CNT_W-1:0] dmem_len_q;
    logic [CNT_W-1:0] dump_len_q;
    logic [CNT_W-1:0] run_len_q;

    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] cur_len;
    logic             word_last;
    logic             cyc_last;
    logic             word_clr;
    logic             word_inc;
    logic             cyc_clr;
    logic             cyc_inc;

    logic             is_load;
    logic             in_hs;
    logic             out_hs;

    logic [NUM_PHASES-1:0] start_nz;
    logic [NUM_PHASES-1:0] len_nz;
    boot_state_t           first_phase;
    boot_state_t           after_imem;
    boot_state_t           after_dmem;
    boot_state_t           after_run;

    // The instruction-memory read port exists only for symmetry.
    wire unused_rdata_ext = ^rdata_ext;

    assign ren_ext = 1'b0;

    assign is_load = (state == ST_LD_IMEM) || (state == ST_LD_DMEM);
    assign in_hs   = is_load && in_valid && in_ready;
    assign out_hs  = (state == ST_DUMP_WT) && out_valid && out_ready;

    // Raw lengths are nonzero exactly when their clamped versions are.
    assign start_nz = {dump_len != '0, run_cycles != '0, dmem_len != '0, imem_len != '0};
    assign len_nz   = {dump_len_q != '0, run_len_q != '0, dmem_len_q != '0, imem_len_q != '0};

    assign first_phase = next_phase(PH_IMEM, start_nz);
    assign after_imem  = next_phase(PH_DMEM, len_nz);
    assign after_dmem  = next_phase(PH_RUN, len_nz);
    assign after_run   = next_phase(PH_DUMP, len_nz);

    // Length that bounds the word counter in the current phase.
    always_comb begin
        cur_len = dump_len_q;
        if (state == ST_LD_IMEM) begin
            cur_len = imem_len_q;
        end else if (state == ST_LD_DMEM) begin
            cur_len = dmem_len_q;
        end
    end

    assign word_clr = ((state == ST_IDLE) && start) || (in_hs && word_last);
    assign word_inc = in_hs || out_hs;
    assign cyc_clr  = (state == ST_IDLE) && start;
    assign cyc_inc  = (state == ST_RUN) && enable;

    boot_word_ctr #(.CNT_W(CNT_W)) u_word_ctr (
        .clk    (clk),
        .arst_n (arst_n),
        .clr    (word_clr),
        .inc    (word_inc),
        .limit  (cur_len),
        .cnt    (word_cnt),
        .last   (word_last)
    );

    boot_word_ctr #(.CNT_W(CNT_W)) u_cyc_ctr (
        .clk    (clk),
        .arst_n (arst_n),
        .clr    (cyc_clr),
        .inc    (cyc_inc),
        .limit  (run_len_q),
        .cnt    (cyc_cnt),
        .last   (cyc_last)
    );

    // Session FSM. Every phase spends its first cycle with its strobe low
    // (in_ready, enable, ren_ext_2), which keeps one idle cycle between the
    // last write of a phase and the first activity of the next.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state       <= ST_IDLE;
            imem_len_q  <= '0;
            dmem_len_q  <= '0;
            dump_len_q  <= '0;
            run_len_q   <= '0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            enable      <= 1'b0;
            addr_ext    <= '0;
            wdata_ext   <= '0;
            wen_ext     <= 1'b0;
            addr_ext_2  <= '0;
            wdata_ext_2 <= '0;
            wen_ext_2   <= 1'b0;
            ren_ext_2   <= 1'b0;
        end else begin
            wen_ext   <= 1'b0;
            wen_ext_2 <= 1'b0;
            ren_ext_2 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        imem_len_q <= clamp_len(imem_len, IMEM_WORDS);
                        dmem_len_q <= clamp_len(dmem_len, DMEM_WORDS);
                        dump_len_q <= clamp_len(dump_len, DMEM_WORDS);
                        run_len_q  <= run_cycles;
                        state      <= first_phase;
                        busy       <= (first_phase != ST_DONE);
                        done       <= (first_phase == ST_DONE);
                    end
                end
                ST_LD_IMEM: begin
                    if (!in_ready) begin
                        in_ready <= 1'b1;
                    end else if (in_valid) begin
                        wen_ext   <= 1'b1;
                        addr_ext  <= word_addr(word_cnt);
                        wdata_ext <= 32'(in_data);
                        if (word_last) begin
                            in_ready <= 1'b0;
                            state    <= after_imem;
                            if (after_imem == ST_DONE) begin
                                busy <= 1'b0;
                                done <= 1'b1;
                            end
                        end
                    end
                end
                ST_LD_DMEM: begin
                    if (!in_ready) begin
                        in_ready <= 1'b1;
                    end else if (in_valid) begin
                        wen_ext_2   <= 1'b1;
                        addr_ext_2  <= word_addr(word_cnt);
                        wdata_ext_2 <= 32'(in_data);
                        if (word_last) begin
                            in_ready <= 1'b0;
                            state    <= after_dmem;
                            if (after_dmem == ST_DONE) begin
                                busy <= 1'b0;
                                done <= 1'b1;
                            end
                        end
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        enable <= 1'b1;
                    end else if (cyc_last) begin
                        enable <= 1'b0;
                        state  <= after_run;
                        if (after_run == ST_DONE) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                        end
                    end
                end
                ST_DUMP_RD: begin
                    if (!ren_ext_2) begin
                        ren_ext_2  <= 1'b1;
                        addr_ext_2 <= word_addr(word_cnt);
                    end else begin
                        state <= ST_DUMP_WT;
                    end
                end
                ST_DUMP_WT: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= DATA_W'(rdata_ext_2);
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        if (word_last) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_DUMP_RD;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Directed bench for cpu_boot_ctrl with behavioural instruction/data memories
// and a scoreboard that checks every memory write and every dumped word.
module tb_cpu_boot_ctrl;

    logic        clk;
    logic        arst_n;
    logic        start;
    logic [31:0] imem_len, dmem_len, dump_len, run_cycles;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy, done, enable;
    logic [31:0] addr_ext, wdata_ext, rdata_ext;
    logic        wen_ext, ren_ext;
    logic [31:0] addr_ext_2, wdata_ext_2, rdata_ext_2;
    logic        wen_ext_2, ren_ext_2;

    logic [31:0] imem [0:511];
    logic [31:0] dmem [0:1023];

    logic [63:0] exp_iw[$];
    logic [63:0] exp_dw[$];
    logic [31:0] exp_out[$];
    logic [63:0] e64;
    logic [31:0] e32;
    logic [31:0] held;
    logic [31:0] last_iaddr;

    int n_checks = 0;
    int n_fail   = 0;
    int en_cnt, overlap_cnt, ren_i_cnt, iw_cnt, act_cnt;

    cpu_boot_ctrl dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .start       (start),
        .imem_len    (imem_len),
        .dmem_len    (dmem_len),
        .dump_len    (dump_len),
        .run_cycles  (run_cycles),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy),
        .done        (done),
        .enable      (enable),
        .addr_ext    (addr_ext),
        .wdata_ext   (wdata_ext),
        .wen_ext     (wen_ext),
        .ren_ext     (ren_ext),
        .rdata_ext   (rdata_ext),
        .addr_ext_2  (addr_ext_2),
        .wdata_ext_2 (wdata_ext_2),
        .wen_ext_2   (wen_ext_2),
        .ren_ext_2   (ren_ext_2),
        .rdata_ext_2 (rdata_ext_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rdata_ext = 32'hDEAD_BEEF;

    // Behavioural memories of the core: one-cycle read latency on the data side.
    always @(posedge clk) begin
        if (wen_ext) imem[addr_ext[10:2]] <= wdata_ext;
        if (wen_ext_2) dmem[addr_ext_2[11:2]] <= wdata_ext_2;
        if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[11:2]];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Monitor: pops the scoreboard on every write and dump handshake.
    always @(negedge clk) begin
        if (arst_n) begin
            if (wen_ext) begin
                iw_cnt++;
                act_cnt++;
                last_iaddr = addr_ext;
                if (exp_iw.size() == 0) begin
                    fail_now("imem_wr_unexpected");
                end else begin
                    e64 = exp_iw.pop_front();
                    check("imem_wr", {addr_ext, wdata_ext}, e64);
                end
            end
            if (wen_ext_2) begin
                act_cnt++;
                if (exp_dw.size() == 0) begin
                    fail_now("dmem_wr_unexpected");
                end else begin
                    e64 = exp_dw.pop_front();
                    check("dmem_wr", {addr_ext_2, wdata_ext_2}, e64);
                end
            end
            if (out_valid && out_ready) begin
                if (exp_out.size() == 0) begin
                    fail_now("out_unexpected");
                end else begin
                    e32 = exp_out.pop_front();
                    check("out_data", 64'(out_data), 64'(e32));
                end
            end
            if (enable) en_cnt++;
            if (ren_ext_2 || enable) act_cnt++;
            if (enable && (wen_ext || wen_ext_2 || ren_ext_2)) overlap_cnt++;
            if (ren_ext) ren_i_cnt++;
        end
    end

    task automatic do_start(input int il, input int dl, input int rc, input int ul);
        @(negedge clk);
        imem_len   = 32'(il);
        dmem_len   = 32'(dl);
        run_cycles = 32'(rc);
        dump_len   = 32'(ul);
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    // Streams n words base+k; a one-cycle valid gap follows word gap_after.
    task automatic send_words(input int n, input logic [31:0] base, input int gap_after);
        int t;
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_data  = base + 32'(k);
            t = 0;
            while (!in_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                fail_now("in_ready_timeout");
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            if (k == gap_after) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int t;
        t = 0;
        while (!(done && !busy) && t < budget) begin
            @(negedge clk);
            t++;
        end
        check(name, 64'(done), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        arst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        imem_len = '0; dmem_len = '0; dump_len = '0; run_cycles = '0;
        en_cnt = 0; overlap_cnt = 0; ren_i_cnt = 0; iw_cnt = 0; act_cnt = 0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_enable", 64'(enable), 64'd0);
        check("rst_addr", {addr_ext, addr_ext_2}, 64'd0);
        check("rst_wdata", {wdata_ext, wdata_ext_2}, 64'd0);
        check("rst_strobes", 64'({wen_ext, ren_ext, wen_ext_2, ren_ext_2}), 64'd0);
        arst_n = 1'b1;
        @(negedge clk);

        // Full session.
        for (int k = 0; k < 3; k++) exp_iw.push_back({32'(k * 4), 32'hA000_0000 + 32'(k)});
        for (int k = 0; k < 2; k++) exp_dw.push_back({32'(k * 4), 32'hD000_0000 + 32'(k)});
        exp_out.push_back(32'hD000_0000);
        exp_out.push_back(32'hD000_0001);
        en_cnt = 0;
        do_start(3, 2, 5, 2);
        check("s1_busy", 64'(busy), 64'd1);
        check("s1_done_clr", 64'(done), 64'd0);
        send_words(3, 32'hA000_0000, -1);
        send_words(2, 32'hD000_0000, -1);
        wait_done("s1_done", 200);
        check("s1_enable_cycles", 64'(en_cnt), 64'd5);
        check("s1_iw_left", 64'(exp_iw.size()), 64'd0);
        check("s1_dw_left", 64'(exp_dw.size()), 64'd0);
        check("s1_out_left", 64'(exp_out.size()), 64'd0);

        // Zero lengths.
        act_cnt = 0;
        do_start(0, 0, 0, 0);
        check("zero_done", 64'(done), 64'd1);
        check("zero_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        check("zero_activity", 64'(act_cnt), 64'd0);

        // Back-pressure on both streams.
        iw_cnt = 0;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) exp_iw.push_back({32'(k * 4), 32'hB000_0000 + 32'(k)});
        exp_out.push_back(32'hD000_0000);
        exp_out.push_back(32'hD000_0001);
        do_start(3, 0, 0, 2);
        send_words(3, 32'hB000_0000, 0);
        begin
            int t;
            t = 0;
            while (!out_valid && t < 50) begin
                @(negedge clk);
                t++;
            end
        end
        check("bp_out_valid", 64'(out_valid), 64'd1);
        held = out_data;
        check("bp_first_word", 64'(out_data), 64'h0000_0000_D000_0000);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_data", 64'(out_data), 64'(held));
        end
        out_ready = 1'b1;
        wait_done("bp_done", 100);
        check("bp_writes", 64'(iw_cnt), 64'd3);
        check("bp_out_left", 64'(exp_out.size()), 64'd0);

        // Clamping, with a start pulse in the middle of the load.
        iw_cnt = 0;
        for (int k = 0; k < 512; k++) exp_iw.push_back({32'(k * 4), 32'hC000_0000 + 32'(k)});
        do_start(600, 0, 0, 0);
        send_words(256, 32'hC000_0000, -1);
        do_start(5, 0, 0, 0);
        send_words(256, 32'hC000_0100, -1);
        in_valid = 1'b1;
        in_data  = 32'h5555_5555;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        wait_done("clamp_done", 50);
        check("clamp_writes", 64'(iw_cnt), 64'd512);
        check("clamp_last_addr", 64'(last_iaddr), 64'(511 << 2));
        check("clamp_iw_left", 64'(exp_iw.size()), 64'd0);
        check("clamp_in_ready", 64'(in_ready), 64'd0);

        // Reset during RUN, then a fresh session.
        do_start(0, 0, 10, 0);
        begin
            int t;
            t = 0;
            while (!enable && t < 20) begin
                @(negedge clk);
                t++;
            end
        end
        check("abort_enable_seen", 64'(enable), 64'd1);
        repeat (2) @(negedge clk);
        arst_n = 1'b0;
        #1;
        check("abort_enable", 64'(enable), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_ready_valid", 64'({in_ready, out_valid}), 64'd0);
        check("abort_addr", {addr_ext, addr_ext_2}, 64'd0);
        @(negedge clk);
        arst_n = 1'b1;
        en_cnt = 0;
        exp_out.push_back(32'hD000_0000);
        do_start(0, 0, 2, 1);
        wait_done("abort_fresh_done", 100);
        check("abort_fresh_enable", 64'(en_cnt), 64'd2);
        check("abort_fresh_out_left", 64'(exp_out.size()), 64'd0);

        check("no_enable_overlap", 64'(overlap_cnt), 64'd0);
        check("imem_ren_never", 64'(ren_i_cnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
